clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
Runtime controller for the cache's clock-division datapath. It holds the active divisor, counts periods, and emits a divided output plus a one-cycle period tick. Divisor changes are taken through a valid/ready handshake and applied only at period boundaries, so the divided output never produces a runt period. Enable/disable is sequenced so a running period always completes before the block stops.

Parameters:
CNT_W, 8, width of divisor and period counter
DEFAULT_DIV, 4, divisor loaded at reset; must be 1..2^CNT_W-1

Ports:
i_Clock  in  1  sole clock
i_Reset  in  1  asynchronous, active-low reset
i_Enable  in  1  level; 1 = run the divider, 0 = stop at end of current period
i_Cfg_Valid  in  1  new divisor offered
i_Cfg_Div  in  CNT_W  offered divisor
o_Cfg_Ready  out  1  controller can accept a divisor
o_Cfg_Err  out  1  one-cycle pulse: accepted divisor was 0 and was discarded
o_Tick  out  1  high in the last cycle of each running period
o_Div_Out  out  1  divided output
o_Cur_Div  out  CNT_W  active divisor
o_Busy  out  1  high in RUN or DRAIN

Behaviour:
- Reset (async, i_Reset=0): state IDLE, count=0, cur_div=DEFAULT_DIV, pending flag=0, o_Cfg_Ready=1, o_Cfg_Err=0, o_Tick=0, o_Div_Out=0, o_Busy=0. Reset mid-period aborts immediately and discards any pending divisor.
- States: IDLE, RUN, DRAIN.
  - IDLE -> RUN when i_Enable=1. Count starts at 0 in the first RUN cycle.
  - RUN -> DRAIN when i_Enable=0 and not at wrap.
  - RUN -> IDLE when i_Enable=0 at wrap.
  - DRAIN -> IDLE at wrap.
  - DRAIN -> RUN when i_Enable returns to 1 before wrap. Counting continues with no gap.
- Counting: in RUN and DRAIN, count increments by 1 each cycle. Wrap occurs when count==cur_div-1; count then goes to 0. In IDLE, count is held at 0.
- Outputs (all derived from registered state only, no input-to-output paths):
  - o_Tick = (RUN or DRAIN) and count==cur_div-1.
  - o_Div_Out = (RUN or DRAIN) and count >= (cur_div>>1). For div=4 the pattern is 0,0,1,1. For div=5 it is 0,0,1,1,1. For div=1 it is constant 1 and o_Tick is also constant 1.
- Handshake: a transfer occurs when i_Cfg_Valid and o_Cfg_Ready are both 1 in the same cycle.
  - i_Cfg_Div=0: transfer completes, value discarded, o_Cfg_Err=1 in the next cycle, cur_div unchanged.
  - In IDLE: cur_div takes the new value in the next cycle and o_Cfg_Ready stays 1.
  - In RUN/DRAIN: value goes to the pending register, pending=1, o_Cfg_Ready=0 from the next cycle.
- Applying a pending divisor: at the next wrap, cur_div takes the pending value, pending clears, and o_Cfg_Ready returns to 1 in the following cycle.
  - A transfer in the same cycle as a wrap is held for the following wrap, giving one full period at the old divisor.
  - A pending value still present when entering IDLE is applied on that same transition.
- Arithmetic: count and the cur_div-1 compare are unsigned, CNT_W bits. The maximum divisor 2^CNT_W-1 must wrap correctly with no overflow.

Test Plan:
- Reset, i_Enable=1, DEFAULT_DIV=4 -> o_Div_Out 0,0,1,1 repeating. o_Tick every 4th cycle, coincident with count=3. o_Busy=1.
- Running at div=4, send divisor 6 at count=1 -> o_Cfg_Ready=0 until the wrap after count=3. The next period is 6 cycles, pattern 0,0,0,1,1,1. o_Cur_Div changes exactly at the wrap.
- Send divisor 3 in the same cycle as a wrap at div=4 -> one further 4-cycle period, then 3-cycle periods (0,1,1).
- i_Enable=0 at count=1 with div=4 -> DRAIN through count=3 with o_Tick at count=3, then IDLE with o_Div_Out=0. A separate run re-raising i_Enable at count=2 -> no gap, next period starts on time.
- Send divisor 0 in RUN -> o_Cfg_Err pulses 1 cycle, o_Cur_Div unchanged. Send divisor 1 -> o_Tick and o_Div_Out constant 1. With CNT_W=8, send 255 -> 255-cycle period, high for 128 cycles.
- Assert i_Reset=0 mid-period with a divisor pending -> all outputs at reset values immediately. After release, divisor is DEFAULT_DIV and the pending value is gone.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// Runtime clock-division controller: holds the active divisor, counts periods and
// emits a divided output plus a last-cycle tick. Divisor updates land only on period boundaries.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic             i_Clock,
  input  logic             i_Reset,
  input  logic             i_Enable,
  input  logic             i_Cfg_Valid,
  input  logic [CNT_W-1:0] i_Cfg_Div,
  output logic             o_Cfg_Ready,
  output logic             o_Cfg_Err,
  output logic             o_Tick,
  output logic             o_Div_Out,
  output logic [CNT_W-1:0] o_Cur_Div,
  output logic             o_Busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] DEFAULT_DIV_V = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ONE_V         = CNT_W'(1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic [CNT_W-1:0] cur_div_reg, cur_div_next;
  logic [CNT_W-1:0] pend_div_reg, pend_div_next;
  logic             pending_reg, pending_next;
  logic             cfg_err_reg, cfg_err_next;

  logic             active;
  logic             wrap;
  logic             xfer;
  logic             div_zero;
  logic             accept;
  logic [CNT_W-1:0] last_count;

  // cur_div is never 0, so cur_div-1 cannot underflow and 2^CNT_W-1 stays in range
  assign active     = (state_reg != IDLE);
  assign last_count = cur_div_reg - ONE_V;
  assign wrap       = active && (count_reg == last_count);
  assign xfer       = i_Cfg_Valid && !pending_reg;
  assign div_zero   = (i_Cfg_Div == '0);
  assign accept     = xfer && !div_zero;

  // State register
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; a period in progress always runs to its wrap before stopping
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (i_Enable) state_next = RUN;
      end
      RUN: begin
        if (!i_Enable) state_next = wrap ? IDLE : DRAIN;
      end
      DRAIN: begin
        if (wrap)          state_next = i_Enable ? RUN : IDLE;
        else if (i_Enable) state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  // Output logic, driven from registered state only
  always_comb begin
    o_Busy      = active;
    o_Tick      = wrap;
    o_Div_Out   = active && (count_reg >= (cur_div_reg >> 1));
    o_Cur_Div   = cur_div_reg;
    o_Cfg_Ready = !pending_reg;
    o_Cfg_Err   = cfg_err_reg;
  end

  // Counter and divisor bookkeeping
  always_comb begin
    count_next    = (active && !wrap) ? (count_reg + ONE_V) : '0;
    cur_div_next  = cur_div_reg;
    pend_div_next = pend_div_reg;
    pending_next  = pending_reg;
    cfg_err_next  = xfer && div_zero;

    if (!active) begin
      if (accept) cur_div_next = i_Cfg_Div;
    end else if (wrap) begin
      if (pending_reg) begin
        cur_div_next = pend_div_reg;
        pending_next = 1'b0;
      end
      // An offer landing on a wrap waits a full period, unless the block is stopping now
      if (accept) begin
        if (state_next == IDLE) begin
          cur_div_next = i_Cfg_Div;
        end else begin
          pend_div_next = i_Cfg_Div;
          pending_next  = 1'b1;
        end
      end
    end else if (accept) begin
      pend_div_next = i_Cfg_Div;
      pending_next  = 1'b1;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      count_reg    <= '0;
      cur_div_reg  <= DEFAULT_DIV_V;
      pend_div_reg <= '0;
      pending_reg  <= 1'b0;
      cfg_err_reg  <= 1'b0;
    end else begin
      count_reg    <= count_next;
      cur_div_reg  <= cur_div_next;
      pend_div_reg <= pend_div_next;
      pending_reg  <= pending_next;
      cfg_err_reg  <= cfg_err_next;
    end
  end

endmodule
